// File: rtl/req_encoder4x2.sv
// Purpose: serialises a 4-bit request vector into ascending 2-bit indices, one per output handshake.
// Latency: first index is valid one cycle after the input handshake; each further index follows the previous handshake by one cycle.
// Backpressure: out, out_valid and out_last hold while out_ready=0; in_ready=0 for the whole time a vector is being emitted.
//
// Ports:
//   clk, rst_n          - single rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   - input handshake; in_ready is 1 only in IDLE (and during reset)
//   in[3:0]             - request vector, bit i set requests index i
//   out[1:0]            - registered index of the current request
//   out_valid/out_ready - output handshake
//   out_last            - registered, 1 when out is the last index of the vector
//   zero_err            - registered one-cycle pulse after an all-zero vector is accepted
module req_encoder4x2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in,
    output logic [1:0] out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       zero_err
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] pending;
    logic [3:0] remaining;
    logic       in_hs;
    logic       out_hs;

    // Index of the lowest set bit; callers only pass nonzero vectors.
    function automatic logic [1:0] lowest_idx(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) begin
                r = 2'(i);
            end
        end
        return r;
    endfunction

    // True when exactly one bit is set, i.e. the lowest index is also the last.
    function automatic logic single_bit(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // in_ready decodes state directly, so it reads 1 throughout reset.
    assign in_ready  = (state == IDLE);
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    // Pending bits left once the index currently on out is consumed.
    assign remaining = pending & ~(4'b0001 << out);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending   <= 4'd0;
            out       <= 2'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            zero_err  <= 1'b0;
        end else begin
            zero_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_hs) begin
                        if (in != 4'd0) begin
                            pending   <= in;
                            out       <= lowest_idx(in);
                            out_valid <= 1'b1;
                            out_last  <= single_bit(in);
                            state     <= EMIT;
                        end else begin
                            // Empty vector: nothing to emit, just flag it.
                            zero_err <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (out_hs) begin
                        if (remaining != 4'd0) begin
                            pending  <= remaining;
                            out      <= lowest_idx(remaining);
                            out_last <= single_bit(remaining);
                        end else begin
                            pending   <= 4'd0;
                            out       <= 2'd0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_req_encoder4x2.sv
module tb_req_encoder4x2;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_vec;
    logic [1:0] out_idx;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       zero_err;

    int vectors;
    int miscompares;

    req_encoder4x2 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_vec),
        .out       (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .zero_err  (zero_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of the indices still owed to the consumer.
    int q[$];
    bit zexp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            zexp = 1'b0;
        end else begin
            bit accept;
            bit consume;
            accept  = in_valid && (q.size() == 0);
            consume = (q.size() > 0) && out_ready;
            if (consume) void'(q.pop_front());
            zexp = accept && (in_vec == 4'd0);
            if (accept) begin
                for (int i = 0; i < 4; i++) begin
                    if (in_vec[i]) q.push_back(i);
                end
            end
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        int e_out;
        int e_vld;
        int e_last;
        e_vld  = (q.size() > 0) ? 1 : 0;
        e_out  = (q.size() > 0) ? q[0] : 0;
        e_last = (q.size() == 1) ? 1 : 0;
        cmp("m_out_valid", int'(out_valid), e_vld);
        cmp("m_out", int'(out_idx), e_out);
        cmp("m_out_last", int'(out_last), e_last);
        cmp("m_in_ready", int'(in_ready), (q.size() == 0) ? 1 : 0);
        cmp("m_zero_err", int'(zero_err), int'(zexp));
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_vec      = 4'd0;
        out_ready   = 1'b0;
        #2;
        cmp("rst_in_ready", int'(in_ready), 1);
        cmp("rst_out_valid", int'(out_valid), 0);
        step();
        step();
        rst_n = 1'b1;

        // Single bit vector.
        in_valid = 1'b1; in_vec = 4'b0001; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        cmp("d1_out", int'(out_idx), 0);
        cmp("d1_valid", int'(out_valid), 1);
        cmp("d1_last", int'(out_last), 1);
        cmp("d1_in_ready", int'(in_ready), 0);
        step();
        cmp("d1_done_valid", int'(out_valid), 0);
        cmp("d1_done_ready", int'(in_ready), 1);

        // Two sparse bits.
        in_valid = 1'b1; in_vec = 4'b1010;
        step();
        in_valid = 1'b0;
        cmp("d2_out_a", int'(out_idx), 1);
        cmp("d2_last_a", int'(out_last), 0);
        step();
        cmp("d2_out_b", int'(out_idx), 3);
        cmp("d2_last_b", int'(out_last), 1);
        step();
        cmp("d2_done", int'(out_valid), 0);

        // All four bits with initial backpressure.
        in_valid = 1'b1; in_vec = 4'b1111; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cmp("d3_hold_out", int'(out_idx), 0);
            cmp("d3_hold_valid", int'(out_valid), 1);
            cmp("d3_hold_last", int'(out_last), 0);
            if (k < 2) step();
        end
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            step();
            cmp("d3_seq_out", int'(out_idx), k);
            cmp("d3_seq_last", int'(out_last), (k == 3) ? 1 : 0);
        end
        step();
        cmp("d3_done", int'(out_valid), 0);

        // All-zero vector.
        in_valid = 1'b1; in_vec = 4'b0000;
        step();
        in_valid = 1'b0;
        cmp("d4_zero_err", int'(zero_err), 1);
        cmp("d4_valid", int'(out_valid), 0);
        cmp("d4_in_ready", int'(in_ready), 1);
        step();
        cmp("d4_zero_err_gone", int'(zero_err), 0);

        // Asynchronous reset in the middle of a vector.
        in_valid = 1'b1; in_vec = 4'b0110; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        cmp("d5_first", int'(out_idx), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        cmp("d5_rst_valid", int'(out_valid), 0);
        cmp("d5_rst_out", int'(out_idx), 0);
        cmp("d5_rst_in_ready", int'(in_ready), 1);
        step();
        rst_n = 1'b1;
        step();
        cmp("d5_after_valid", int'(out_valid), 0);
        cmp("d5_after_ready", int'(in_ready), 1);

        // Vector offered while emitting waits for an IDLE cycle.
        in_valid = 1'b1; in_vec = 4'b0011;
        step();
        in_vec = 4'b1000;
        cmp("d6_out_a", int'(out_idx), 0);
        cmp("d6_blocked_a", int'(in_ready), 0);
        step();
        cmp("d6_out_b", int'(out_idx), 1);
        cmp("d6_blocked_b", int'(in_ready), 0);
        step();
        cmp("d6_idle_valid", int'(out_valid), 0);
        cmp("d6_idle_ready", int'(in_ready), 1);
        step();
        in_valid = 1'b0;
        cmp("d6_out_c", int'(out_idx), 3);
        cmp("d6_last_c", int'(out_last), 1);
        step();

        // Randomized traffic, checked by the compare process.
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            in_vec    = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 99) == 0) begin
                #2;
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/req_encoder4x2.md
REQ_ENCODER4X2 -- requirements
Module: req_encoder4x2

Interface
REQ-001: The block SHALL have no parameters; input width is fixed at 4 and index width at 2.
REQ-002: clk  input  1  single clock; all state changes on the rising edge.
REQ-003: rst_n  input  1  asynchronous, active-low reset.
REQ-004: in_valid  input  1  the request vector on `in` is offered.
REQ-005: in_ready  output  1  the block can accept a vector; equals (state == IDLE).
REQ-006: in  input  4  request vector; bit i set means index i is requested.
REQ-007: out  output  2  binary index of the current request, registered.
REQ-008: out_valid  output  1  `out` holds a valid index, registered.
REQ-009: out_ready  input  1  the consumer accepts `out`.
REQ-010: out_last  output  1  `out` is the final index of the current vector, registered.
REQ-011: zero_err  output  1  one-cycle pulse when an all-zero vector is accepted, registered.

Function
REQ-012: The block SHALL implement two states: IDLE and EMIT.
REQ-013: An input handshake SHALL occur when in_valid=1 and in_ready=1 on a rising clk edge.
REQ-014: On a handshake with in!=0, the block SHALL do all of the following:
- load the vector into a 4-bit pending register;
- enter EMIT;
- on the same edge, drive out = index of the lowest set bit, with out_valid=1.
REQ-015: Latency from the input handshake edge to out_valid=1 SHALL be exactly one cycle.
REQ-016: On a handshake with in==0, the block SHALL do all of the following:
- remain in IDLE;
- leave pending unchanged at zero;
- keep out_valid=0;
- assert zero_err for exactly the following cycle.
REQ-017: zero_err SHALL be 0 in every cycle other than the one defined in REQ-016.
REQ-018: An output handshake SHALL occur when out_valid=1 and out_ready=1 on a rising clk edge.
REQ-019: While out_valid=1 and out_ready=0, out, out_valid and out_last SHALL hold their values unchanged.
REQ-020: On an output handshake, the bit of pending corresponding to `out` SHALL be cleared.
REQ-021: After an output handshake, if pending is still nonzero, the block SHALL do all of the following on the same edge:
- drive out = lowest remaining set bit;
- keep out_valid=1;
- stay in EMIT.
REQ-022: On an output handshake where out_last=1, the block SHALL do all of the following:
- clear pending to 0;
- drive out_valid=0, out_last=0 and out=2'b00;
- return to IDLE.
REQ-023: out_last SHALL be 1 exactly when the current index is the highest set bit of pending, i.e. pending has one bit set.
REQ-024: Indices SHALL be emitted in strictly ascending order; one index per output handshake; the number of handshakes equals the popcount of the accepted vector.
REQ-025: in_ready SHALL be 0 throughout EMIT, including the cycle of the final output handshake.
REQ-026: A vector offered during EMIT SHALL NOT be accepted until the cycle after return to IDLE, giving a one-cycle bubble minimum.
REQ-027: Changes on `in` while in_ready=0 SHALL have no effect on any output or internal state.

Reset
REQ-028: While rst_n=0, the following SHALL be forced immediately, independent of clk:
- state = IDLE;
- pending = 4'b0000;
- out = 2'b00;
- out_valid = 0;
- out_last = 0;
- zero_err = 0.
REQ-029: in_ready SHALL read 1 while rst_n=0; no handshake can occur until rst_n is deasserted.
REQ-030: Reset asserted mid-EMIT SHALL discard all remaining pending indices; none SHALL be emitted after release.
REQ-031: The first handshake after reset release SHALL be accepted on the first rising edge with rst_n=1 and in_valid=1.

Verification
REQ-032: Reset, then in=4'b0001 with out_ready=1:
- out=00, out_valid=1 and out_last=1 one cycle after accept;
- out_valid=0 and in_ready=1 on the next cycle.
REQ-033: in=4'b1010 with out_ready=1:
- out=01 (out_last=0) on the first cycle;
- out=11 (out_last=1) on the next cycle;
- exactly two out_valid cycles, then IDLE.
REQ-034: in=4'b1111 with out_ready=0 for 3 cycles, then 1:
- out=00 and out_valid=1 held stable for 3 cycles;
- then 00, 01, 10, 11 on consecutive cycles, out_last only on 11.
REQ-035: in=4'b0000 with in_valid=1 for one cycle:
- zero_err=1 for exactly one cycle;
- out_valid stays 0 and in_ready stays 1.
REQ-036: in=4'b0110, with rst_n pulsed low asynchronously right after the first output handshake (out=01):
- out_valid=0 and out=00 immediately;
- index 10 is never emitted;
- in_ready=1 after release.
REQ-037: in=4'b0011, then in_valid held with in=4'b1000 during EMIT:
- second vector not accepted until after the out=01 handshake plus one IDLE cycle;
- then out=11, out_last=1.
